// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word skid buffer, so back-to-back
// words leave the shifter with no idle cycle between them.
module bit_serializer #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         x,
  output logic         x_valid,
  output logic         word_done,
  output logic         busy
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [W-1:0]   hold_q, hold_d;
  logic           hold_full_q, hold_full_d;

  logic           handshake;
  logic           active_bit;
  logic [W-1:0]   shifted;

  // Bit order only changes which end is presented and which way the word moves.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign active_bit = shift_q[W-1];
      assign shifted    = {shift_q[W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign active_bit = shift_q[0];
      assign shifted    = {1'b0, shift_q[W-1:1]};
    end
  endgenerate

  assign in_ready  = ~hold_full_q & ~rst;
  assign handshake = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (state_q == IDLE) begin
      if (handshake) begin
        state_d = SHIFT;
        cnt_d   = '0;
        shift_d = in_data;
      end
    end else if (cnt_q != LAST) begin
      cnt_d   = cnt_q + 1'b1;
      shift_d = shifted;
      if (handshake) begin
        hold_d      = in_data;
        hold_full_d = 1'b1;
      end
    end else begin
      // Last bit of the word: refill from the hold register first, then from
      // a word arriving on this very edge, otherwise go quiet.
      cnt_d = '0;
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_d      = '0;
        hold_full_d = 1'b0;
      end else if (handshake) begin
        shift_d = in_data;
      end else begin
        state_d = IDLE;
        shift_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign x_valid   = (state_q == SHIFT);
  assign x         = x_valid ? active_bit : IDLE_BIT;
  assign word_done = x_valid & (cnt_q == LAST);
  assign busy      = x_valid | hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (MSB-first, LSB-first, idle-high)
// checked by a bit-queue scoreboard plus a cycle table and corner sequences.
module tb_bit_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst      = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data  = '0;

  logic rdy_m, x_m, xv_m, wd_m, busy_m;
  logic rdy_l, x_l, xv_l, wd_l, busy_l;
  logic rdy_i, x_i, xv_i, wd_i, busy_i;

  bit_serializer #(.W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .x(x_m), .x_valid(xv_m), .word_done(wd_m), .busy(busy_m));

  bit_serializer #(.W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .x(x_l), .x_valid(xv_l), .word_done(wd_l), .busy(busy_l));

  bit_serializer #(.W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_i (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_i), .x(x_i), .x_valid(xv_i), .word_done(wd_i), .busy(busy_i));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted word becomes W queued bits in transmit order.
  typedef struct packed {logic b; logic last;} sbit_t;
  sbit_t q_msb[$];
  sbit_t q_lsb[$];
  bit    model_hs;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_msb.delete();
      q_lsb.delete();
    end else begin
      model_hs = in_valid && (q_msb.size() <= W);
      if (q_msb.size() > 0) begin
        void'(q_msb.pop_front());
        void'(q_lsb.pop_front());
      end
      if (model_hs) begin
        for (int i = 0; i < W; i++) begin
          q_msb.push_back('{in_data[W-1-i], (i == W-1)});
          q_lsb.push_back('{in_data[i], (i == W-1)});
        end
      end
    end
  end

  task automatic mon(input string n, input sbit_t fr, input int sz, input logic idle,
                     input logic rdy, input logic xv, input logic xx,
                     input logic wd, input logic bz);
    logic v;
    v = (sz > 0) && !rst;
    chk({n, "_xv"},   32'(xv),  32'(v));
    chk({n, "_x"},    32'(xx),  32'(v ? fr.b : idle));
    chk({n, "_wd"},   32'(wd),  32'(v && fr.last));
    chk({n, "_busy"}, 32'(bz),  32'(v));
    chk({n, "_rdy"},  32'(rdy), 32'(!rst && (sz <= W)));
  endtask

  sbit_t front_m, front_l;
  always @(negedge clk) begin
    front_m = (q_msb.size() > 0) ? q_msb[0] : '{1'b0, 1'b0};
    front_l = (q_lsb.size() > 0) ? q_lsb[0] : '{1'b0, 1'b0};
    mon("sb_msb",  front_m, q_msb.size(), 1'b0, rdy_m, xv_m, x_m, wd_m, busy_m);
    mon("sb_lsb",  front_l, q_lsb.size(), 1'b0, rdy_l, xv_l, x_l, wd_l, busy_l);
    mon("sb_idle", front_m, q_msb.size(), 1'b1, rdy_i, xv_i, x_i, wd_i, busy_i);
  end

  // Per-cycle vectors for the MSB-first instance: reset, release, 0xA5 then 0x3C.
  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic       rdy;
    logic       xv;
    logic       x;
    logic       wd;
    logic       busy;
  } vec_t;

  vec_t tbl[20];
  logic [W-1:0] got_word;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      rst      = tbl[i].rst;
      in_valid = tbl[i].vld;
      in_data  = tbl[i].data;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy", i),  32'(rdy_m),  32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_xv", i),   32'(xv_m),   32'(tbl[i].xv));
      chk($sformatf("tbl%0d_x", i),    32'(x_m),    32'(tbl[i].x));
      chk($sformatf("tbl%0d_wd", i),   32'(wd_m),   32'(tbl[i].wd));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_m), 32'(tbl[i].busy));
      #1;
    end

    // LSB-first 0x01: a single 1 followed by seven 0s.
    in_valid = 1'b1;
    in_data  = 8'h01;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk($sformatf("lsb_x%0d", i),  32'(x_l),  32'(i == 0));
      chk($sformatf("lsb_wd%0d", i), 32'(wd_l), 32'(i == W-1));
      if (i == 0) begin
        #1;
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("lsb_end_xv", 32'(xv_l), 32'd0);
    #1;

    // Reset mid-word with 0xF0 in flight and 0x0F held.
    in_valid = 1'b1;
    in_data  = 8'hF0;
    @(negedge clk);
    #1;
    in_data = 8'h0F;
    @(negedge clk);
    chk("abort_hold_rdy", 32'(rdy_m), 32'd0);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_x",    32'(x_m),    32'd0);
    chk("abort_xv",   32'(xv_m),   32'd0);
    chk("abort_busy", 32'(busy_m), 32'd0);
    chk("abort_rdy",  32'(rdy_m),  32'd0);
    chk("abort_wd",   32'(wd_m),   32'd0);
    chk("abort_idle", 32'(x_i),    32'd1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("release_rdy", 32'(rdy_m), 32'd1);
    chk("release_xv",  32'(xv_m),  32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      got_word[W-1-i] = x_m;
      if (i == 0) begin
        #1;
        in_valid = 1'b0;
      end
    end
    chk("after_reset_word", 32'(got_word), 32'h55);
    @(negedge clk);
    chk("after_reset_xv", 32'(xv_m), 32'd0);
    #1;

    // 0xFF with hold empty; 0x00 handshaken on the edge ending bit 7.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk);
    chk("b2b_wd7",  32'(wd_m),  32'd1);
    chk("b2b_rdy7", 32'(rdy_m), 32'd1);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(negedge clk);
    chk("b2b_gap_xv",  32'(xv_m), 32'd1);
    chk("b2b_gap_x",   32'(x_m),  32'd0);
    chk("b2b_idle_xv", 32'(xv_i), 32'd1);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_high_x",  32'(x_i),  32'd1);
    chk("idle_high_xv", 32'(xv_i), 32'd0);
    #1;

    // Random traffic; the scoreboard checks every cycle.
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      @(negedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (24) @(negedge clk);
    chk("drain_busy", 32'(busy_m), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
